// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding, forwarding selects and register-match helper
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    // r0 is hardwired to zero, so a write to it never creates a dependency
    function automatic logic reg_match(input logic wr, input logic [4:0] dest, input logic [4:0] src);
        return wr && (dest != 5'd0) && (dest == src);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_fwd_unit.sv
// rtl/pipe_ctrl_hazard_fwd_unit.sv - combinational register comparisons; PIPE_CTRL_FWD_EN selects forwarding
import pipe_ctrl_pkg::*;

module hazard_fwd_unit (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_dest,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_dest,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_dest,
    output logic       load_use,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

`ifdef PIPE_CTRL_FWD_EN
    logic unused_hfu;

    // only a load result is too late to forward into the next instruction
    assign load_use = reg_match(ex_mem_read, ex_dest, id_rs) ||
                      reg_match(ex_mem_read && id_uses_rt, ex_dest, id_rt);

    assign fwd_a = reg_match(mem_reg_write, mem_dest, ex_rs) ? FWD_EXMEM :
                   reg_match(wb_reg_write,  wb_dest,  ex_rs) ? FWD_MEMWB : FWD_REGFILE;
    assign fwd_b = reg_match(mem_reg_write, mem_dest, ex_rt) ? FWD_EXMEM :
                   reg_match(wb_reg_write,  wb_dest,  ex_rt) ? FWD_MEMWB : FWD_REGFILE;

    assign unused_hfu = ex_reg_write;
`else
    logic unused_hfu;

    // without bypass paths any in-flight writer of an ID source must drain first
    assign load_use = reg_match(ex_reg_write, ex_dest, id_rs) ||
                      reg_match(ex_reg_write && id_uses_rt, ex_dest, id_rt) ||
                      reg_match(mem_reg_write, mem_dest, id_rs) ||
                      reg_match(mem_reg_write && id_uses_rt, mem_dest, id_rt);

    assign fwd_a = FWD_REGFILE;
    assign fwd_b = FWD_REGFILE;

    assign unused_hfu = ^{ex_rs, ex_rt, ex_mem_read, wb_reg_write, wb_dest};
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush FSM with perf counters; PIPE_CTRL_FWD_EN enables forwarding
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dest,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_dest,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_dest,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write_en,
    output logic        ifid_write_en,
    output logic        idex_write_en,
    output logic        exmem_write_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic        memwb_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_nx;
    logic [7:0] wait_cnt;
    logic       load_use;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic       mem_stall;
    logic       timeout_hit;
    logic       flush_evt;

    hazard_fwd_unit u_hfu (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_dest       (ex_dest),
        .mem_reg_write (mem_reg_write),
        .mem_dest      (mem_dest),
        .wb_reg_write  (wb_reg_write),
        .wb_dest       (wb_dest),
        .load_use      (load_use),
        .fwd_a         (fwd_a_raw),
        .fwd_b         (fwd_b_raw)
    );

    assign mem_stall = dmem_req && !dmem_ready;
    assign fwd_a     = rst ? FWD_REGFILE : fwd_a_raw;
    assign fwd_b     = rst ? FWD_REGFILE : fwd_b_raw;

    always_comb begin
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        idex_write_en  = 1'b1;
        exmem_write_en = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        exmem_bubble   = 1'b0;
        memwb_bubble   = 1'b0;
        state_nx       = state;
        timeout_hit    = 1'b0;
        flush_evt      = 1'b0;

        if (rst) begin
            state_nx = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        {pc_write_en, ifid_write_en, idex_write_en, exmem_write_en} = 4'b0000;
                        memwb_bubble = 1'b1;
                        state_nx     = MEM_WAIT;
                    end else if (branch_taken) begin
                        ifid_flush   = 1'b1;
                        idex_bubble  = 1'b1;
                        exmem_bubble = 1'b1;
                        flush_evt    = 1'b1;
                        state_nx     = BR_FLUSH;
                    end else if (load_use) begin
                        pc_write_en   = 1'b0;
                        ifid_write_en = 1'b0;
                        idex_bubble   = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_nx = RUN;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        // give up on the access and release the pipe as if it completed
                        timeout_hit = 1'b1;
                        state_nx    = RUN;
                    end else begin
                        {pc_write_en, ifid_write_en, idex_write_en, exmem_write_en} = 4'b0000;
                        memwb_bubble = 1'b1;
                    end
                end
                BR_FLUSH: begin
                    if (mem_stall) begin
                        {pc_write_en, ifid_write_en, idex_write_en, exmem_write_en} = 4'b0000;
                        memwb_bubble = 1'b1;
                        state_nx     = MEM_WAIT;
                    end else begin
                        state_nx = RUN;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= 8'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            state <= state_nx;
            if (state != MEM_WAIT)
                wait_cnt <= 8'd0;
            else
                wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit)
                mem_timeout <= 1'b1;
            if (!pc_write_en && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (flush_evt && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl (default and short-timeout instances)
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic        id_uses_rt, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
    logic        branch_taken, dmem_req, dmem_ready;

    logic        pc_we, ifid_we, idex_we, exmem_we, ifid_fl, idex_bb, exmem_bb, memwb_bb, mto;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cycles, flush_count;

    logic        t_pc_we, t_ifid_we, t_idex_we, t_exmem_we, t_ifid_fl, t_idex_bb, t_exmem_bb, t_memwb_bb, t_mto;
    logic [1:0]  t_fwd_a, t_fwd_b;
    logic [15:0] t_stall_cycles, t_flush_count;

    int checks = 0;
    int errors = 0;

    wire [3:0] en   = {pc_we, ifid_we, idex_we, exmem_we};
    wire [3:0] bb   = {ifid_fl, idex_bb, exmem_bb, memwb_bb};
    wire [3:0] t_en = {t_pc_we, t_ifid_we, t_idex_we, t_exmem_we};

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_dest(ex_dest), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write_en(pc_we), .ifid_write_en(ifid_we), .idex_write_en(idex_we), .exmem_write_en(exmem_we),
        .ifid_flush(ifid_fl), .idex_bubble(idex_bb), .exmem_bubble(exmem_bb), .memwb_bubble(memwb_bb),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mto),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipe_ctrl #(.MEM_TIMEOUT(3)) dut_to (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_dest(ex_dest), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write_en(t_pc_we), .ifid_write_en(t_ifid_we), .idex_write_en(t_idex_we), .exmem_write_en(t_exmem_we),
        .ifid_flush(t_ifid_fl), .idex_bubble(t_idex_bb), .exmem_bubble(t_exmem_bb), .memwb_bubble(t_memwb_bb),
        .fwd_a(t_fwd_a), .fwd_b(t_fwd_b), .mem_timeout(t_mto),
        .stall_cycles(t_stall_cycles), .flush_count(t_flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_dest = 0;
        mem_reg_write = 0; mem_dest = 0; wb_reg_write = 0; wb_dest = 0;
        branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5'd5; id_rs = 5'd5;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with every stimulus active: outputs must stay benign
        clear_inputs();
        rst = 1;
        set_load_use();
        branch_taken = 1; dmem_req = 1;
        mem_reg_write = 1; mem_dest = 5'd3; ex_rs = 5'd3;
        #1;
        chk("rst_en", en, 4'hF);
        chk("rst_bb", bb, 4'h0);
        chk("rst_fwd_a", fwd_a, 2'b00);
        tick();
        chk("rst_stall", stall_cycles, 0);
        chk("rst_flush", flush_count, 0);
        chk("rst_mto", mto, 0);
        rst = 0;
        clear_inputs();
        #1;
        chk("idle_en", en, 4'hF);
        chk("idle_bb", bb, 4'h0);

        // load-use on rs
        set_load_use();
        #1;
        chk("lu_en", en, 4'b0011);
        chk("lu_bb", bb, 4'b0100);
        tick();
        clear_inputs();
        #1;
        chk("lu_stall_cnt", stall_cycles, 1);
        chk("lu_release_en", en, 4'hF);

        // r0 never hazards
        ex_mem_read = 1; ex_reg_write = 1; ex_dest = 0; id_rs = 0;
        #1;
        chk("r0_no_stall", en, 4'hF);

        // rt match only counts when rt is read
        clear_inputs();
        ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5'd6; id_rt = 5'd6; id_uses_rt = 0;
        #1;
        chk("rt_unused_en", en, 4'hF);
        id_uses_rt = 1;
        #1;
        chk("rt_used_en", en, 4'b0011);
        tick();
        chk("rt_stall_cnt", stall_cycles, 2);

        // non-load ALU producer in EX, and MEM-stage producer
        clear_inputs();
        ex_reg_write = 1; ex_dest = 5'd7; id_rt = 5'd7; id_uses_rt = 1;
        #1;
        chk("alu_ex_dep_en", en, FWD_ON ? 4'hF : 4'b0011);
        chk("alu_ex_dep_fwd_a", fwd_a, 2'b00);
        chk("alu_ex_dep_fwd_b", fwd_b, 2'b00);
        clear_inputs();
        mem_reg_write = 1; mem_dest = 5'd9; id_rs = 5'd9;
        #1;
        chk("mem_dep_en", en, FWD_ON ? 4'hF : 4'b0011);

        // forwarding priority and r0
        clear_inputs();
        mem_reg_write = 1; mem_dest = 5'd3; wb_reg_write = 1; wb_dest = 5'd3;
        ex_rs = 5'd3; ex_rt = 5'd3;
        #1;
        chk("fwd_a_double", fwd_a, FWD_ON ? 2'b10 : 2'b00);
        chk("fwd_b_double", fwd_b, FWD_ON ? 2'b10 : 2'b00);
        mem_reg_write = 0;
        #1;
        chk("fwd_a_memwb", fwd_a, FWD_ON ? 2'b01 : 2'b00);
        ex_rs = 0; wb_dest = 0;
        #1;
        chk("fwd_a_r0", fwd_a, 2'b00);

        // branch beats load-use; BR_FLUSH suppresses the hazard stall
        clear_inputs();
        set_load_use();
        branch_taken = 1;
        #1;
        chk("br_en", en, 4'hF);
        chk("br_bb", bb, 4'b1110);
        tick();
        branch_taken = 0;
        #1;
        chk("brf_en", en, 4'hF);
        chk("brf_bb", bb, 4'h0);
        chk("br_flush_cnt", flush_count, 1);
        tick();
        chk("after_brf_stall", en, 4'b0011);
        clear_inputs();

        // memory wait, ready after 4 stalled cycles (short-timeout instance hits count==3 with ready)
        dmem_req = 1;
        #1;
        chk("mw_bb", bb, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            chk("mw_en", en, 4'h0);
            tick();
        end
        dmem_ready = 1;
        #1;
        chk("mw_release_en", en, 4'hF);
        chk("mw_release_bb", bb, 4'h0);
        tick();
        clear_inputs();
        #1;
        chk("mw_stall_cnt", stall_cycles, 6);
        chk("mw_ready_beats_to", t_mto, 0);

        // memory stall inside BR_FLUSH
        branch_taken = 1;
        tick();
        branch_taken = 0; dmem_req = 1;
        #1;
        chk("brf_mem_en", en, 4'h0);
        chk("brf_mem_bb", bb, 4'b0001);
        tick();
        dmem_ready = 1;
        #1;
        chk("brf_mem_release", en, 4'hF);
        tick();
        clear_inputs();
        chk("brf_mem_flush_cnt", flush_count, 2);
        chk("brf_mem_stall_cnt", stall_cycles, 7);

        // timeout on the MEM_TIMEOUT=3 instance
        dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_wait_en", t_en, 4'h0);
            tick();
        end
        chk("to_release_en", t_en, 4'hF);
        chk("to_long_still_wait", en, 4'h0);
        tick();
        chk("to_set", t_mto, 1);
        dmem_req = 0; dmem_ready = 1;
        tick();
        clear_inputs();
        tick();
        chk("to_sticky", t_mto, 1);
        chk("to_long_clear", mto, 0);
        chk("to_short_stall_cnt", t_stall_cycles, 11);
        chk("to_long_stall_cnt", stall_cycles, 12);
        rst = 1;
        tick();
        rst = 0;
        chk("to_rst_clear", t_mto, 0);
        chk("to_rst_stall", t_stall_cycles, 0);

        // reset in BR_FLUSH returns straight to RUN
        branch_taken = 1;
        tick();
        branch_taken = 0;
        rst = 1;
        set_load_use();
        #1;
        chk("rst_brf_en", en, 4'hF);
        chk("rst_brf_bb", bb, 4'h0);
        tick();
        rst = 0;
        #1;
        chk("rst_brf_run_stall", en, 4'b0011);
        chk("rst_brf_flush_cnt", flush_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter: MEM_TIMEOUT, 255, max MEM_WAIT cycles before abort (1..255).
REQ-002 SHALL use one clock and a synchronous, active-high reset; all state updates on posedge clk.
REQ-003 Ports SHALL be:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  id_rs, id_rt  in  5  source regs of the instruction in ID
  id_uses_rt  in  1  ID instruction reads rt
  ex_rs, ex_rt  in  5  source regs of the instruction in EX
  ex_reg_write, ex_mem_read  in  1  EX instruction writes reg / is a load
  ex_dest  in  5  EX destination reg
  mem_reg_write  in  1  MEM instruction writes reg
  mem_dest  in  5  MEM destination reg
  wb_reg_write  in  1  WB instruction writes reg
  wb_dest  in  5  WB destination reg
  branch_taken  in  1  taken branch resolved at EX/MEM output
  dmem_req, dmem_ready  in  1  data-memory access / completion
  pc_write_en, ifid_write_en, idex_write_en, exmem_write_en  out  1  register load enables
  ifid_flush, idex_bubble, exmem_bubble, memwb_bubble  out  1  insert NOP into that register
  fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
  mem_timeout  out  1  sticky: a memory wait was aborted
  stall_cycles, flush_count  out  16  saturating performance counters

Function
REQ-004 FSM states SHALL be RUN, MEM_WAIT, BR_FLUSH; state registered, outputs combinational from state and inputs.
REQ-005 RUN priority SHALL be: memory wait > branch > load-use hazard > normal.
REQ-006 Memory wait: dmem_req=1 and dmem_ready=0 in RUN SHALL deassert all four write enables, assert memwb_bubble, go to MEM_WAIT.
REQ-007 MEM_WAIT SHALL hold the same outputs until dmem_ready=1; in that cycle all enables=1, no bubbles, next state RUN.
REQ-008 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment per waiting cycle; at count==MEM_TIMEOUT SHALL set mem_timeout, behave as if dmem_ready=1, return to RUN.
REQ-009 Branch: branch_taken=1 in RUN SHALL assert ifid_flush, idex_bubble, exmem_bubble, keep pc_write_en=1, go to BR_FLUSH.
REQ-010 BR_FLUSH SHALL last exactly one cycle with all enables=1, hazard stall suppressed, then RUN; a dmem_req stall in BR_FLUSH still takes priority.
REQ-011 Load-use stall (RUN only): ex_mem_read=1, ex_dest!=0, ex_dest matches id_rs, or id_rt with id_uses_rt=1 -> pc_write_en=0, ifid_write_en=0, idex_bubble=1 for that cycle; state stays RUN.
REQ-012 Register 0 SHALL never cause a hazard or forward.
REQ-013 Forwarding, per operand: EX/MEM match (mem_reg_write, mem_dest!=0, equal) -> 10; else MEM/WB match -> 01; else 00. EX/MEM SHALL win on a double match.
REQ-014 stall_cycles SHALL increment each cycle pc_write_en=0; flush_count SHALL increment on each REQ-009 event; both saturate at 16'hFFFF.

Reset
REQ-015 rst=1 SHALL force state RUN, clear the wait counter, mem_timeout, stall_cycles and flush_count.
REQ-016 While rst=1, outputs SHALL be: all enables 1, all bubbles/flush 0, fwd 00.
REQ-017 rst during MEM_WAIT or BR_FLUSH SHALL abandon that state with no flush or timeout side effects.

Configuration
REQ-018 Macro PIPE_CTRL_FWD_EN SHALL select the forwarding feature.
REQ-019 Defined: REQ-011 and REQ-013 apply.
REQ-020 Undefined: fwd_a/fwd_b tied 00; REQ-011 stall SHALL also trigger when the ID source matches ex_dest with ex_reg_write=1, or mem_dest with mem_reg_write=1, with the ex_mem_read condition dropped.

Structure
REQ-021 Package pipe_ctrl_pkg SHALL hold the state enum and the FWD_REGFILE/FWD_EXMEM/FWD_MEMWB constants.
REQ-022 Register comparisons SHALL live in combinational sub-module hazard_fwd_unit; the FSM and counters stay in pipe_ctrl.

Verification
REQ-023 Load-use: ex_mem_read=1, ex_dest=5, id_rs=5 -> one cycle pc_write_en=0, idex_bubble=1, stall_cycles=1.
REQ-024 Forwarding (macro on): mem_dest=3 and wb_dest=3, both writing, ex_rs=3 -> fwd_a=10; with mem_reg_write=0 -> fwd_a=01; ex_rs=0 -> 00.
REQ-025 Branch: branch_taken=1 one cycle -> three bubbles/flush that cycle, BR_FLUSH next cycle with no stall despite load-use inputs, flush_count=1.
REQ-026 Memory wait: dmem_req=1, dmem_ready after 4 cycles -> enables low 4 cycles, RUN on 5th, stall_cycles=4.
REQ-027 Timeout: MEM_TIMEOUT=3, dmem_ready held 0 -> mem_timeout=1 after 3 wait cycles, RUN, stays set until rst.
REQ-028 Macro off: ex_reg_write=1, ex_dest=7, id_rt=7, id_uses_rt=1 -> stall; fwd_a/fwd_b always 00.
